// File: rtl/debouncer.sv
// Multi-channel level debouncer. A shared sample counter produces a periodic
// sample strobe; each channel accepts a high level only after PULSE_CNT_MAX
// consecutive high samples and drops it on the first low input cycle.
// Registered rise/fall strobes mark the edges of the filtered level.
module debouncer #(
    parameter int unsigned WIDTH          = 1,
    parameter int unsigned SAMPLE_CNT_MAX = 62500,
    parameter int unsigned PULSE_CNT_MAX  = 200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] glitchy_signal,
    output logic [WIDTH-1:0] debounced_signal,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse
);

    localparam int unsigned SampleCntW = (SAMPLE_CNT_MAX > 1) ? $clog2(SAMPLE_CNT_MAX) : 1;
    localparam int unsigned PulseCntW  = $clog2(PULSE_CNT_MAX + 1);

    localparam logic [SampleCntW-1:0] SampleLast = SampleCntW'(SAMPLE_CNT_MAX - 1);
    localparam logic [PulseCntW-1:0]  PulseMax   = PulseCntW'(PULSE_CNT_MAX);

    logic [SampleCntW-1:0] sample_cnt_q, sample_cnt_d;
    logic                  sample_pulse;
    logic [PulseCntW-1:0]  pulse_cnt_q [WIDTH];
    logic [PulseCntW-1:0]  pulse_cnt_d [WIDTH];
    logic [WIDTH-1:0]      prev_q;

    // Shared sample timebase: strobe on the last count, then wrap to zero.
    always_comb begin
        sample_pulse = (sample_cnt_q == SampleLast);
        sample_cnt_d = sample_pulse ? '0 : sample_cnt_q + SampleCntW'(1);
    end

    // Per-channel saturating count of consecutive high samples; any low cycle clears it.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            pulse_cnt_d[i] = pulse_cnt_q[i];
            if (!glitchy_signal[i]) begin
                pulse_cnt_d[i] = '0;
            end else if (sample_pulse && (pulse_cnt_q[i] != PulseMax)) begin
                pulse_cnt_d[i] = pulse_cnt_q[i] + PulseCntW'(1);
            end
        end
    end

    // State registers; reset overrides every other update.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_cnt_q <= '0;
            prev_q       <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                pulse_cnt_q[i] <= '0;
            end
        end else begin
            sample_cnt_q <= sample_cnt_d;
            prev_q       <= debounced_signal;
            for (int i = 0; i < WIDTH; i++) begin
                pulse_cnt_q[i] <= pulse_cnt_d[i];
            end
        end
    end

    // Outputs decode registered state only, so there is no input-to-output path.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            debounced_signal[i] = (pulse_cnt_q[i] == PulseMax);
        end
        rise_pulse = debounced_signal & ~prev_q;
        fall_pulse = ~debounced_signal & prev_q;
    end

endmodule
